// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings and helpers for the pipeline hazard/stall unit.
// Tuse/Tnew encodings, MDU start codes, tracker entry type and the per-source hazard check.
package hazard_stall_unit_pkg;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] MD_START_NONE = 2'b00;
  localparam logic [1:0] MD_START_MUL  = 2'b01;
  localparam logic [1:0] MD_START_DIV  = 2'b10;

  localparam int unsigned DEFAULT_MULT_CYCLES = 5;
  localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } tracker_t;

  // A source stalls when some in-flight producer will not have its result by the time it is needed.
  function automatic logic src_hazard(logic [4:0] a, logic [1:0] tuse, tracker_t e, tracker_t m);
    logic e_hit;
    logic m_hit;
    e_hit = (a == e.a3) && (tuse < e.tnew);
    m_hit = (a == m.a3) && (tuse < m.tnew);
    return (a != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Multiply/divide busy counter: loads the unit latency on a start, then counts down to idle.
module md_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MultCycles = DEFAULT_MULT_CYCLES,
  parameter int unsigned DivCycles  = DEFAULT_DIV_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] start_i,
  output logic       busy_o
);

  logic [3:0] cnt_q, cnt_d;

  // A start while busy reloads rather than being ignored.
  always_comb begin
    cnt_d = cnt_q;
    case (start_i)
      MD_START_MUL: cnt_d = 4'(MultCycles);
      MD_START_DIV: cnt_d = 4'(DivCycles);
      default: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall generator for the 5-stage core: tracks E/M destinations with remaining Tnew and
// freezes D when a source is needed too early. Define MDU_HAZARD_EN to also track the MDU.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_A1,
  input  logic [1:0] ID_Tuse1,
  input  logic [4:0] ID_A2,
  input  logic [1:0] ID_Tuse2,
  input  logic [4:0] ID_A3,
  input  logic [1:0] ID_Tnew,
  input  logic       ID_IsMD,
  input  logic [1:0] E_MDStart,
  output logic       Stall,
  output logic       DEClr,
  output logic       MDBusy
);

  tracker_t e_q, e_d;
  tracker_t m_q, m_d;
  logic     hazard1, hazard2, md_stall;

  always_comb begin
    hazard1 = src_hazard(ID_A1, ID_Tuse1, e_q, m_q);
    hazard2 = src_hazard(ID_A2, ID_Tuse2, e_q, m_q);
    Stall   = hazard1 | hazard2 | md_stall;
    DEClr   = Stall;

    if (Stall) begin
      e_d.a3   = 5'd0;
      e_d.tnew = TNEW_NONE;
    end else begin
      e_d.a3   = ID_A3;
      e_d.tnew = ID_Tnew;
    end

    // Moving E->M consumes one cycle of remaining latency, saturating at zero.
    m_d.a3   = e_q.a3;
    m_d.tnew = (e_q.tnew != TNEW_NONE) ? e_q.tnew - 2'd1 : TNEW_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

`ifdef MDU_HAZARD_EN
  md_busy_counter #(
    .MultCycles(MULT_CYCLES),
    .DivCycles (DIV_CYCLES)
  ) u_md_busy (
    .clk_i  (clk),
    .rst_i  (reset),
    .start_i(E_MDStart),
    .busy_o (MDBusy)
  );

  // An op starting in E this cycle has not loaded the counter yet but already blocks HI/LO users.
  assign md_stall = ID_IsMD & (MDBusy | (E_MDStart != MD_START_NONE));
`else
  logic unused_md;
  assign unused_md = ^{ID_IsMD, E_MDStart, 4'(MULT_CYCLES), 4'(DIV_CYCLES)};
  assign md_stall  = 1'b0;
  assign MDBusy    = 1'b0;
`endif

endmodule
